// File: rtl/port_reader_pkg.sv
// ---------------------------------------------------------------------------
// port_reader_pkg
// Shared definitions for the MAC receive-FIFO reader:
//   - FSM state encoding
//   - descriptor field positions (error flag, length field)
//   - skid-buffer entry layout
// No ports (package).
// ---------------------------------------------------------------------------
package port_reader_pkg;

    localparam int LEN_W   = 12;
    localparam int ERR_BIT = 15;
    localparam int LEN_MSB = 11;
    localparam int LEN_LSB = 0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PTR_WAIT = 3'd1,
        LOAD     = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } skid_entry_t;

endpackage

// File: rtl/port_reader_skid.sv
// ---------------------------------------------------------------------------
// port_reader_skid
// Two-entry FIFO holding {data, sof, eof} bytes that came back from the data
// FIFO but could not be handed to the fabric yet.
// Ports:
//   clk      core clock
//   rstn     synchronous active-low reset (empties the buffer)
//   i_push   write i_din at the tail
//   i_pop    drop the head entry
//   i_din    entry to write
//   o_head   current head entry (undefined content when o_count == 0)
//   o_count  number of occupied entries (0..2)
// The caller never pushes into a full buffer without a simultaneous pop and
// never pops an empty one.
// ---------------------------------------------------------------------------
module port_reader_skid
    import port_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_push,
    input  logic        i_pop,
    input  skid_entry_t i_din,
    output skid_entry_t o_head,
    output logic [1:0]  o_count
);

    skid_entry_t r_mem [2];
    logic [1:0]  r_count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    r_mem[r_count[0]] <= i_din;
                    r_count           <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem[0] <= r_mem[1];
                    r_count  <= r_count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new entry lands behind whatever
                    // is left after the head leaves.
                    if (r_count == 2'd2) begin
                        r_mem[0] <= r_mem[1];
                        r_mem[1] <= i_din;
                    end else begin
                        r_mem[0] <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_mem[0];
    assign o_count = r_count;

endmodule

// File: rtl/port_frame_reader.sv
// ---------------------------------------------------------------------------
// port_frame_reader
// Pops one descriptor from the MAC receive pointer FIFO, then reads exactly
// that many bytes from the data FIFO and presents them as a valid/ready byte
// stream with sof/eof markers. Oversize frames are drained and counted.
// Build option: define PORT_READER_DROP_ERR_EN to also drain frames whose
// descriptor error bit is set (out_err then stays 0); otherwise such frames
// are forwarded with out_err on their eof byte.
// Ports:
//   clk, rstn                    core clock, synchronous active-low reset
//   ptr_fifo_empty/rd/dout       descriptor FIFO (standard read, 1-cycle)
//   data_fifo_rd/dout            byte FIFO (standard read, 1-cycle)
//   out_valid/ready/data         fabric byte stream
//   out_sof/eof/err/len          frame markers, error flag, frame length
//   frame_cnt, drop_cnt          wrapping statistics counters
// ---------------------------------------------------------------------------
module port_frame_reader
    import port_reader_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ptr_fifo_empty,
    output logic             ptr_fifo_rd,
    input  logic [15:0]      ptr_fifo_dout,
    output logic             data_fifo_rd,
    input  logic [7:0]       data_fifo_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_err,
    output logic [LEN_W-1:0] out_len,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t            r_state, w_state_next;
    logic [LEN_W-1:0]  r_len;
    logic              r_err;
    logic [LEN_W-1:0]  r_req;
    logic              r_inflight;
    logic              r_if_sof;
    logic              r_if_eof;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_ptr_rd;
    logic              w_data_rd;
    logic              w_frame_done;
    logic              w_drop_done;
    logic              w_err_drop;
    logic              w_valid;
    logic              w_accept;
    logic              w_bypass;
    logic [1:0]        w_occ;
    logic [1:0]        w_skid_count;
    logic              w_skid_push;
    logic              w_skid_pop;
    skid_entry_t       w_skid_head;
    skid_entry_t       w_incoming;
    skid_entry_t       w_head;
    logic              w_unused_rsvd;

    assign w_unused_rsvd = ^ptr_fifo_dout[14:12];

`ifdef PORT_READER_DROP_ERR_EN
    assign w_err_drop = r_err;
`else
    assign w_err_drop = 1'b0;
`endif

    // Byte returning from the data FIFO this cycle, tagged when it was read.
    assign w_incoming = '{data: data_fifo_dout, sof: r_if_sof, eof: r_if_eof};

    // With the skid empty the returning byte is shown directly, which gives
    // the fall-through latency; otherwise the oldest buffered byte leads.
    assign w_bypass    = (w_skid_count == 2'd0);
    assign w_head      = w_bypass ? w_incoming : w_skid_head;
    assign w_valid     = !w_bypass || r_inflight;
    assign w_accept    = w_valid && out_ready;
    assign w_skid_push = r_inflight && !(w_bypass && w_accept);
    assign w_skid_pop  = w_accept && !w_bypass;
    assign w_occ       = w_skid_count + {1'b0, r_inflight};

    port_reader_skid u_skid (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_skid_push),
        .i_pop   (w_skid_pop),
        .i_din   (w_incoming),
        .o_head  (w_skid_head),
        .o_count (w_skid_count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_rd     = 1'b0;
        w_data_rd    = 1'b0;
        w_frame_done = 1'b0;
        w_drop_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!ptr_fifo_empty) begin
                    w_ptr_rd     = 1'b1;
                    w_state_next = PTR_WAIT;
                end
            end
            PTR_WAIT: w_state_next = LOAD;
            LOAD: begin
                if (r_len == '0) begin
                    w_state_next = IDLE;
                end else if ((r_len > MAX_LEN_L) || w_err_drop) begin
                    w_state_next = DRAIN;
                end else begin
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                // At most two bytes outstanding: what the skid holds plus
                // what is still coming back from the FIFO.
                w_data_rd = (w_occ < 2'd2) && (r_req < r_len);
                if (w_accept && w_head.eof) begin
                    w_frame_done = 1'b1;
                    w_state_next = IDLE;
                end
            end
            DRAIN: begin
                if (r_req < r_len) begin
                    w_data_rd = 1'b1;
                end else begin
                    w_drop_done  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_len       <= '0;
            r_err       <= 1'b0;
            r_req       <= '0;
            r_inflight  <= 1'b0;
            r_if_sof    <= 1'b0;
            r_if_eof    <= 1'b0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (r_state == PTR_WAIT) begin
                r_len <= ptr_fifo_dout[LEN_MSB:LEN_LSB];
                r_err <= ptr_fifo_dout[ERR_BIT];
            end
            if (r_state == LOAD) begin
                r_req <= '0;
            end else if (w_data_rd) begin
                r_req <= r_req + 12'd1;
            end
            r_inflight <= w_data_rd && (r_state == STREAM);
            if (w_data_rd) begin
                r_if_sof <= (r_req == '0);
                r_if_eof <= (r_req == r_len - 12'd1);
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            if (w_drop_done) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    // Strobes are masked while reset is held so no FIFO entry is consumed
    // before the state registers have been cleared.
    assign ptr_fifo_rd  = w_ptr_rd && rstn;
    assign data_fifo_rd = w_data_rd && rstn;
    assign out_valid    = w_valid;
    assign out_data     = w_valid ? w_head.data : 8'h00;
    assign out_sof      = w_valid && w_head.sof;
    assign out_eof      = w_valid && w_head.eof;
    assign out_len      = w_valid ? r_len : '0;
`ifdef PORT_READER_DROP_ERR_EN
    assign out_err      = 1'b0;
`else
    assign out_err      = w_valid && w_head.eof && r_err;
`endif
    assign frame_cnt    = r_frame_cnt;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_port_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_port_frame_reader
// Directed frames into models of the pointer/data FIFOs; expected bytes go
// into a scoreboard queue when a frame is queued and a monitor pops and
// compares on every out_valid & out_ready handshake.
// ---------------------------------------------------------------------------
module tb_port_frame_reader;

`ifdef PORT_READER_DROP_ERR_EN
    localparam bit DROP_ERR = 1'b1;
`else
    localparam bit DROP_ERR = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        ptr_fifo_empty;
    logic        ptr_fifo_rd;
    logic [15:0] ptr_fifo_dout;
    logic        data_fifo_rd;
    logic [7:0]  data_fifo_dout;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic        out_err;
    logic [11:0] out_len;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    port_frame_reader #(.MAX_LEN(1518), .CNT_W(16)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .ptr_fifo_empty (ptr_fifo_empty),
        .ptr_fifo_rd    (ptr_fifo_rd),
        .ptr_fifo_dout  (ptr_fifo_dout),
        .data_fifo_rd   (data_fifo_rd),
        .data_fifo_dout (data_fifo_dout),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_sof        (out_sof),
        .out_eof        (out_eof),
        .out_err        (out_err),
        .out_len        (out_len),
        .frame_cnt      (frame_cnt),
        .drop_cnt       (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FIFO models (standard read) ----------------
    logic [15:0] ptr_mem  [0:63];
    logic [7:0]  data_mem [0:4095];
    int ptr_wr = 0, ptr_rd = 0, data_wr = 0, data_rd = 0;

    assign ptr_fifo_empty = (ptr_wr == ptr_rd);

    always @(posedge clk) begin
        if (!rstn) begin
            ptr_rd         <= 0;
            data_rd        <= 0;
            ptr_fifo_dout  <= 16'h0;
            data_fifo_dout <= 8'h0;
        end else begin
            if (ptr_fifo_rd && (ptr_rd < ptr_wr)) begin
                ptr_fifo_dout <= ptr_mem[ptr_rd[5:0]];
                ptr_rd        <= ptr_rd + 1;
            end
            if (data_fifo_rd) begin
                data_fifo_dout <= data_mem[data_rd[11:0]];
                data_rd        <= data_rd + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0]  d;
        logic        sof;
        logic        eof;
        logic        err;
        logic [11:0] len;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0, miscompares = 0;
    int   exp_frames = 0, exp_drops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    int cyc = 0;
    int mon_issued = 0, mon_acc = 0;
    bit chk_ahead = 1'b0;
    bit lat_arm = 1'b0;
    int lat_ptr = -1, lat_drd = -1, lat_ov = -1;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rstn) begin
                if (lat_arm) begin
                    if (ptr_fifo_rd && lat_ptr < 0) lat_ptr = cyc;
                    if (data_fifo_rd && lat_drd < 0) lat_drd = cyc;
                    if (out_valid && lat_ov < 0) lat_ov = cyc;
                end
                if (data_fifo_rd) begin
                    check("data_pop_in_range", data_rd < data_wr, 1);
                    mon_issued++;
                    if (chk_ahead) check("rd_ahead_le2", (mon_issued - mon_acc) <= 2, 1);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_byte: got %0h, expected no output", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        $display("byte %02h sof=%0b eof=%0b err=%0b", out_data, out_sof, out_eof, out_err);
                        check("out_data", out_data, e.d);
                        check("out_sof", out_sof, e.sof);
                        check("out_eof", out_eof, e.eof);
                        if (e.sof) check("out_len", out_len, e.len);
                        if (e.eof) check("out_err", out_err, e.err);
                    end
                    mon_acc++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_frame(input logic [15:0] desc, input logic [7:0] seed);
        int   len;
        bit   err;
        bit   fwd;
        exp_t e;
        len = int'(desc[11:0]);
        err = desc[15];
        fwd = (len != 0) && (len <= 1518) && !(DROP_ERR && err);
        for (int i = 0; i < len; i++) begin
            data_mem[data_wr[11:0]] = 8'(int'(seed) + i * 3);
            if (fwd) begin
                e.d   = 8'(int'(seed) + i * 3);
                e.sof = (i == 0);
                e.eof = (i == len - 1);
                e.err = err && (i == len - 1);
                e.len = desc[11:0];
                exp_q.push_back(e);
            end
            data_wr++;
        end
        if (len != 0) begin
            if (fwd) exp_frames++;
            else     exp_drops++;
        end
        ptr_mem[ptr_wr[5:0]] = desc;
        ptr_wr++;
        $display("queued descriptor %04h", desc);
    endtask

    task automatic wait_done(input string name, input int budget, input bit toggle);
        int n;
        int settle;
        n = 0;
        settle = 0;
        while (settle < 4 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (toggle) out_ready = !out_ready;
            if (exp_q.size() == 0 && ptr_rd == ptr_wr && data_rd == data_wr) settle++;
            else settle = 0;
        end
        out_ready = 1'b1;
        check(name, settle >= 4, 1);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_cnt"}, frame_cnt, exp_frames);
        check({tag, "_drop_cnt"}, drop_cnt, exp_drops);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rstn      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ptr_fifo_rd", ptr_fifo_rd, 0);
        check("rst_data_fifo_rd", data_fifo_rd, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_len", out_len, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // 64-byte frame, fabric always ready
        lat_arm = 1'b1;
        push_frame(16'h0040, 8'h10);
        wait_done("t1_done", 400, 1'b0);
        lat_arm = 1'b0;
        check("t1_lat_data_rd", lat_drd - lat_ptr, 3);
        check("t1_lat_out_valid", lat_ov - lat_ptr, 4);
        check("t1_data_pops", data_rd, 64);
        check_counts("t1");

        // same size, ready toggling every cycle
        chk_ahead = 1'b1;
        push_frame(16'h0040, 8'h80);
        wait_done("t2_done", 600, 1'b1);
        chk_ahead = 1'b0;
        check("t2_data_pops", data_rd, 128);
        check_counts("t2");

        // error descriptor
        push_frame(16'h8040, 8'h33);
        wait_done("t3_done", 400, 1'b0);
        check("t3_data_pops", data_rd, 192);
        check_counts("t3");

        // oversize then normal
        push_frame(16'h0600, 8'h01);
        push_frame(16'h0040, 8'hC0);
        wait_done("t4_done", 4000, 1'b0);
        check("t4_data_pops", data_rd, 192 + 1536 + 64);
        check_counts("t4");

        // zero length then single byte
        push_frame(16'h0000, 8'h00);
        push_frame(16'h0001, 8'hEE);
        wait_done("t5_done", 200, 1'b0);
        check("t5_data_pops", data_rd, 192 + 1536 + 64 + 1);
        check_counts("t5");

        // reset in the middle of a 100-byte frame
        n = mon_acc;
        push_frame(16'h0064, 8'h44);
        begin
            int k;
            k = 0;
            while ((mon_acc - n) < 30 && k < 400) begin
                @(posedge clk);
                #1;
                k++;
            end
            check("t6_reach_byte30", (mon_acc - n) >= 30, 1);
        end
        rstn = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        ptr_wr     = 0;
        data_wr    = 0;
        exp_frames = 0;
        exp_drops  = 0;
        rstn       = 1'b1;
        @(negedge clk);
        check("t6_out_valid", out_valid, 0);
        check("t6_out_data", out_data, 0);
        check("t6_out_sof", out_sof, 0);
        check("t6_out_eof", out_eof, 0);
        check("t6_out_len", out_len, 0);
        check("t6_ptr_fifo_rd", ptr_fifo_rd, 0);
        check("t6_data_fifo_rd", data_fifo_rd, 0);
        check_counts("t6");
        @(posedge clk);
        #1;

        // reader recovers from IDLE after the reset
        push_frame(16'h0003, 8'h90);
        wait_done("t7_done", 200, 1'b0);
        check_counts("t7");
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/port_frame_reader.md
# port_frame_reader

Switch-core-side consumer of a MAC port's receive FIFO pair. Pops one frame descriptor from the 16-bit pointer FIFO, reads exactly that many bytes from the 8-bit data FIFO and presents them as a valid/ready byte stream with start/end markers to the switch fabric. It is the reader for the FIFOs written by the MAC receive path and runs entirely in the core clock domain.

## Interface
- MAX_LEN, 1518: largest legal frame length in bytes; longer descriptors are drained.
- CNT_W, 16: width of statistics counters.
- clk  in  1  core clock.
- rstn  in  1  synchronous active-low reset.
- ptr_fifo_empty  in  1  descriptor FIFO empty.
- ptr_fifo_rd  out  1  descriptor pop strobe.
- ptr_fifo_dout  in  16  descriptor: [15] error flag, [14:12] reserved, [11:0] length in bytes.
- data_fifo_rd  out  1  data byte pop strobe.
- data_fifo_dout  in  8  data byte.
- out_valid  out  1  output byte valid.
- out_ready  in  1  fabric accepts byte.
- out_data  out  8  frame byte.
- out_sof  out  1  first byte of frame.
- out_eof  out  1  last byte of frame.
- out_err  out  1  frame error flag, meaningful with out_eof.
- out_len  out  12  frame length, meaningful with out_sof.
- frame_cnt  out  CNT_W  frames forwarded, wraps.
- drop_cnt  out  CNT_W  frames drained, wraps.

## Operation
- Both FIFOs are standard-read: dout valid the cycle after the rd strobe.
- States: IDLE, PTR_WAIT, LOAD, STREAM, DRAIN.
- IDLE: ptr_fifo_empty low -> assert ptr_fifo_rd one cycle -> PTR_WAIT.
- PTR_WAIT: capture ptr_fifo_dout into len/err registers -> LOAD.
- LOAD: length 0 -> IDLE, no data reads, no counter change; length > MAX_LEN, or error bit set with drop feature enabled -> DRAIN; otherwise -> STREAM.
- STREAM: data_fifo_rd asserted when (occupied skid entries + reads in flight) < 2 and bytes_requested < len; returned bytes enter a 2-entry skid buffer; head of buffer drives out_*. sof on byte index 0, eof on index len-1. After eof handshake (out_valid & out_ready) -> IDLE, frame_cnt += 1.
- DRAIN: data_fifo_rd asserted every cycle until len bytes popped; no output; then drop_cnt += 1 -> IDLE.
- Data FIFO is never popped beyond len for a frame; ptr FIFO popped exactly once per frame.
- Byte counters 12 bits; bytes_requested and bytes_sent compared against captured len, never wrap within a frame.
- out_data/out_sof/out_eof/out_err/out_len held stable while out_valid & !out_ready.

## Timing
- Reset values: ptr_fifo_rd 0, data_fifo_rd 0, out_valid 0, out_sof 0, out_eof 0, out_err 0, out_data 0, out_len 0, frame_cnt 0, drop_cnt 0, state IDLE, skid empty.
- Latency: ptr_fifo_empty falling edge seen at cycle 0 -> ptr_fifo_rd cycle 0 -> first data_fifo_rd cycle 3 -> first out_valid cycle 4.
- Throughput with out_ready held high: one byte per cycle; next frame's ptr_fifo_rd earliest the cycle after eof handshake.
- Reset mid-frame: all state cleared in one cycle; FIFOs are reset by the same rstn, so no resynchronisation logic.
- out_ready low stalls data_fifo_rd within one cycle; skid absorbs the in-flight byte, no loss.
- Counter increment and state return to IDLE occur in the same cycle.

## Configuration
- PORT_READER_DROP_ERR_EN defined: descriptors with error bit set are drained, counted in drop_cnt, never reach the fabric; out_err constant 0.
- Not defined: error frames forwarded normally with out_err = 1 on the eof byte; counted in frame_cnt. Oversize frames are drained in both builds.

## Structure
- Package port_reader_pkg: state enum, descriptor field positions (ERR_BIT 15, LEN_MSB 11, LEN_LSB 0), LEN_W = 12.
- Sub-module port_reader_skid: 2-entry buffer of {data, sof, eof}, push/pop with count output; the FSM stays in the top.

## Test plan
- Single 64-byte frame, descriptor 0x0040, out_ready high -> 64 bytes in order, sof on byte 0, eof on byte 63, frame_cnt 1, exactly 64 data_fifo_rd.
- Same frame with out_ready toggling 1/0 every cycle -> identical byte sequence, no duplicates, data_fifo_rd never more than 2 ahead of accepted bytes.
- Descriptor 0x8040 (error, 64 B) -> macro defined: no out_valid, 64 pops, drop_cnt 1; undefined: frame forwarded, out_err 1 with eof.
- Descriptor 0x0600 (1536 B > MAX_LEN) followed by 0x0040 -> first drained (drop_cnt 1), second forwarded intact.
- Descriptor 0x0000 then 0x0001 -> no output for first, single byte with sof and eof both high for second.
- rstn low for one cycle at byte 30 of a 100-byte frame -> all outputs at reset values next cycle, counters 0, state IDLE.
